// File: rtl/noc_cmd_ingress.sv
// noc_cmd_ingress
// Ingress stage between the NOC device-side byte interface and the perm
// packages. It registers the ctl/data byte stream and detects the ctl falling
// edge that ends a command header. It then decodes the address/data lengths
// from the header byte and pushes a fixed-length burst of tagged words
// {ctl, data, des} into an internal synchronous FIFO that the downstream
// reader drains.
//
// Ports:
//   clk              single clock, all logic on posedge
//   rst              asynchronous reset, active-low
//   noc_to_dev_ctl   NOC control bit, high during the header byte
//   noc_to_dev_data  NOC data byte
//   rd_en            FIFO pop request
//   data_out         registered FIFO read word {ctl, data[7:0], des[7:0]}
//   empty / full     registered FIFO status, derived from the entry count
//   cmd_des          destination byte latched at the end of the header
//   cmd_busy         high while the burst counter is nonzero
//   ovf              sticky overflow flag
//
// Build option: define NOC_INGRESS_OVF_EN to enable the sticky overflow flag.
// Without it, ovf is tied low. Words that arrive while the FIFO is full are
// dropped in both builds.
module noc_cmd_ingress #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             noc_to_dev_ctl,
    input  logic [7:0]       noc_to_dev_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] data_out,
    output logic             empty,
    output logic             full,
    output logic [7:0]       cmd_des,
    output logic             cmd_busy,
    output logic             ovf
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned LW = 10;

    logic             ctl_q;
    logic             ctl_f;
    logic             ctl_r;
    logic [WIDTH-1:0] stg;
    logic [3:0]       alen;
    logic [7:0]       dlen;
    logic [LW-1:0]    cnt;

    logic [3:0]       alen_new;
    logic [7:0]       dlen_new;
    logic [LW-1:0]    cnt_next;

    logic             wr;
    logic             do_wr;
    logic             do_rd;
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic [WIDTH-1:0] mem [DEPTH];

    // Edge detectors on the raw ctl input against its one-cycle delayed copy.
    // The rising detector is kept for visibility but nothing consumes it.
    always_comb begin
        ctl_f = ctl_q & ~noc_to_dev_ctl;
        ctl_r = ~ctl_q & noc_to_dev_ctl;
    end

    logic unused_sig;
    assign unused_sig = ^{ctl_r, alen, dlen};

    // Header decode and burst counter next state. The header byte is held in
    // stg while ctl falls, so the lengths come from stg rather than the live
    // input.
    always_comb begin
        alen_new = 4'd1 << stg[15:14];
        dlen_new = 8'd1 << stg[13:11];
        cnt_next = cnt;
        if (ctl_f) begin
            cnt_next = LW'(alen_new) + LW'(dlen_new) + LW'(2);
        end else if (cnt != '0) begin
            cnt_next = cnt - LW'(1);
        end
    end

    // The header word is written on the falling edge, and the burst words
    // follow while cnt is nonzero.
    // When the FIFO is full, a concurrent pop frees a slot in the same cycle.
    always_comb begin
        wr    = ctl_f | (cnt != '0);
        do_rd = rd_en & ~empty;
        do_wr = wr & (~full | rd_en);
        count_next = count;
        case ({do_wr, do_rd})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Stage register, edge history, and command decode state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctl_q    <= 1'b0;
            stg      <= '0;
            alen     <= '0;
            dlen     <= '0;
            cnt      <= '0;
            cmd_des  <= '0;
            cmd_busy <= 1'b0;
        end else begin
            ctl_q    <= noc_to_dev_ctl;
            stg      <= {noc_to_dev_ctl, noc_to_dev_data, cmd_des};
            cnt      <= cnt_next;
            cmd_busy <= (cnt_next != '0);
            if (ctl_f) begin
                alen    <= alen_new;
                dlen    <= dlen_new;
                cmd_des <= noc_to_dev_data;
            end
        end
    end

    // FIFO storage. It has no reset because the pointers and count define
    // which entries are valid.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wptr] <= stg;
        end
    end

    // FIFO pointers, count, registered status flags, and the read port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            data_out <= '0;
        end else begin
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == CW'(DEPTH));
            if (do_wr) begin
                wptr <= wptr + AW'(1);
            end
            if (do_rd) begin
                rptr     <= rptr + AW'(1);
                data_out <= mem[rptr];
            end
        end
    end

`ifdef NOC_INGRESS_OVF_EN
    // Sticky flag that records any burst word lost to a full FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else if (wr & full & ~rd_en) begin
            ovf <= 1'b1;
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_noc_cmd_ingress.sv
// Directed bench for noc_cmd_ingress. Build with NOC_INGRESS_OVF_EN to
// expect the sticky overflow flag.
module tb_noc_cmd_ingress;

    logic        clk;
    logic        rst_n;
    logic        ctl;
    logic [7:0]  data;
    logic        rd_en;
    logic [16:0] data_out;
    logic        empty;
    logic        full;
    logic [7:0]  cmd_des;
    logic        cmd_busy;
    logic        ovf;

    int tests;
    int fails;
    int busy_cnt;

`ifdef NOC_INGRESS_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    noc_cmd_ingress #(.DEPTH(16), .WIDTH(17)) dut (
        .clk             (clk),
        .rst             (rst_n),
        .noc_to_dev_ctl  (ctl),
        .noc_to_dev_data (data),
        .rd_en           (rd_en),
        .data_out        (data_out),
        .empty           (empty),
        .full            (full),
        .cmd_des         (cmd_des),
        .cmd_busy        (cmd_busy),
        .ovf             (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic cyc(input logic c, input logic [7:0] d, input logic r);
        ctl   = c;
        data  = d;
        rd_en = r;
        @(posedge clk);
        #1;
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] exp);
        cyc(1'b0, 8'h00, 1'b1);
        chk(tag, 32'(data_out), exp);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_data_out"}, 32'(data_out), 32'h0);
        chk({tag, "_empty"},    32'(empty),    32'h1);
        chk({tag, "_full"},     32'(full),     32'h0);
        chk({tag, "_cmd_des"},  32'(cmd_des),  32'h0);
        chk({tag, "_busy"},     32'(cmd_busy), 32'h0);
        chk({tag, "_ovf"},      32'(ovf),      32'h0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        ctl   = 1'b0;
        data  = 8'h00;
        rd_en = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("por");
        rst_n = 1'b1;
        cyc(1'b0, 8'h00, 1'b0);

        // Minimal header: alen=1, dlen=1 gives cnt=4 and 5 words.
        cyc(1'b1, 8'h00, 1'b0);
        cyc(1'b0, 8'h5A, 1'b0);
        chk("min_cmd_des", 32'(cmd_des), 32'h5A);
        chk("min_empty", 32'(empty), 32'h0);
        busy_cnt = int'(cmd_busy);
        for (int i = 1; i <= 4; i++) begin
            cyc(1'b0, 8'(i), 1'b0);
            if (cmd_busy) busy_cnt++;
        end
        chk("min_busy_cycles", 32'(busy_cnt), 32'd4);
        cyc(1'b0, 8'h00, 1'b0);
        pop_chk("min_w0", 32'h10000);
        pop_chk("min_w1", 32'h05A00);
        pop_chk("min_w2", 32'h0015A);
        pop_chk("min_w3", 32'h0025A);
        pop_chk("min_w4", 32'h0035A);
        chk("min_empty_after", 32'(empty), 32'h1);
        cyc(1'b0, 8'h00, 1'b1);
        chk("rd_empty_hold", 32'(data_out), 32'h0035A);
        chk("rd_empty_flag", 32'(empty), 32'h1);

        // Header 0xC0: alen=8, dlen=1 gives cnt=11 and 12 words.
        cyc(1'b1, 8'hC0, 1'b0);
        cyc(1'b0, 8'h11, 1'b0);
        chk("c0_cmd_des", 32'(cmd_des), 32'h11);
        busy_cnt = int'(cmd_busy);
        for (int i = 0; i < 11; i++) begin
            cyc(1'b0, 8'(32'h20 + i), 1'b0);
            if (cmd_busy) busy_cnt++;
        end
        chk("c0_busy_cycles", 32'(busy_cnt), 32'd11);
        chk("c0_not_full", 32'(full), 32'h0);
        cyc(1'b0, 8'h00, 1'b0);
        chk("c0_hold_before_rd", 32'(data_out), 32'h0035A);
        pop_chk("c0_w0", 32'h1C05A);
        pop_chk("c0_w1", 32'h0115A);
        for (int i = 0; i < 10; i++) begin
            pop_chk("c0_wn", (32'(32'h20 + i) << 8) | 32'h11);
        end
        chk("c0_empty_after", 32'(empty), 32'h1);

        // Header 0x38: alen=1, dlen=128 gives cnt=131. The FIFO fills and
        // later words are dropped.
        cyc(1'b1, 8'h38, 1'b0);
        cyc(1'b0, 8'h77, 1'b0);
        chk("38_cmd_des", 32'(cmd_des), 32'h77);
        busy_cnt = int'(cmd_busy);
        for (int k = 0; k < 150; k++) begin
            cyc(1'b0, 8'(128 + k), (k == 20) || (k == 21));
            if (cmd_busy) busy_cnt++;
            if (k == 13) chk("38_full_pre", 32'(full), 32'h0);
            if (k == 14) chk("38_full_at16", 32'(full), 32'h1);
            if (k == 15) chk("38_ovf_set", 32'(ovf), 32'(OVF_EXP));
            if (k == 20) begin
                chk("38_rdwr_full_w0", 32'(data_out), 32'h13811);
                chk("38_rdwr_full_flag", 32'(full), 32'h1);
            end
            if (k == 21) chk("38_rdwr_full_w1", 32'(data_out), 32'h07711);
            if (k == 22) chk("38_full_held", 32'(full), 32'h1);
        end
        chk("38_busy_cycles", 32'(busy_cnt), 32'd131);
        chk("38_ovf_sticky", 32'(ovf), 32'(OVF_EXP));
        for (int j = 2; j < 16; j++) begin
            pop_chk("38_drain", (32'(128 + j - 2) << 8) | 32'h77);
        end
        pop_chk("38_drain_rw0", 32'h09377);
        pop_chk("38_drain_rw1", 32'h09477);
        chk("38_empty_after", 32'(empty), 32'h1);

        // A second header arrives while cnt=3, so the counter reloads to 5.
        cyc(1'b1, 8'h00, 1'b0);
        cyc(1'b0, 8'hA1, 1'b0);
        cyc(1'b1, 8'h08, 1'b0);
        cyc(1'b0, 8'hC3, 1'b0);
        chk("rs_cmd_des", 32'(cmd_des), 32'hC3);
        busy_cnt = int'(cmd_busy);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 8'(32'hD0 + i), 1'b0);
            if (cmd_busy) busy_cnt++;
        end
        chk("rs_busy_cycles", 32'(busy_cnt), 32'd5);
        pop_chk("rs_w0", 32'h10077);
        pop_chk("rs_w1", 32'h0A177);
        pop_chk("rs_w2", 32'h108A1);
        pop_chk("rs_w3", 32'h0C3A1);
        pop_chk("rs_w4", 32'h0D0C3);
        pop_chk("rs_w5", 32'h0D1C3);
        pop_chk("rs_w6", 32'h0D2C3);
        pop_chk("rs_w7", 32'h0D3C3);
        chk("rs_empty_after", 32'(empty), 32'h1);

        // Assert reset asynchronously mid-burst with 3 words queued.
        cyc(1'b1, 8'h00, 1'b0);
        cyc(1'b0, 8'h55, 1'b0);
        cyc(1'b0, 8'h01, 1'b0);
        cyc(1'b0, 8'h02, 1'b0);
        chk("mid_busy", 32'(cmd_busy), 32'h1);
        chk("mid_not_empty", 32'(empty), 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_state("async");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1'b0, 8'h00, 1'b0);
        chk("post_rst_empty", 32'(empty), 32'h1);
        chk("post_rst_busy", 32'(cmd_busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/noc_cmd_ingress.md
Name: noc_cmd_ingress

Overview:
- Ingress stage between the NOC device-side byte interface and the perm packages.
- Registers the incoming ctl/data stream and detects the ctl falling edge (end of command header).
- Decodes address/data lengths from the header and pushes a fixed-length burst of 17-bit tagged words into an internal synchronous FIFO, drained by the downstream reader.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 4..256.
- WIDTH, 17, FIFO word width; fixed as {ctl, data[7:0], des[7:0]}.

Ports:
- clk  in  1  single clock, all logic on posedge
- rst  in  1  reset, asynchronous, active-low (asserted when 0)
- noc_to_dev_ctl  in  1  NOC control bit, high during header byte
- noc_to_dev_data  in  8  NOC data byte
- rd_en  in  1  FIFO pop request
- data_out  out  17  registered FIFO read word
- empty  out  1  FIFO empty
- full  out  1  FIFO full
- cmd_des  out  8  latched command destination byte
- cmd_busy  out  1  high while the burst counter is nonzero
- ovf  out  1  sticky overflow flag (see Optional Feature)

Behaviour:
- Reset (rst=0, async):
  - data_out=0, empty=1, full=0, cmd_des=0, cmd_busy=0, ovf=0.
  - FIFO pointers/count=0; stage register=0; alen=0, dlen=0, cnt=0; ctl_q=0.
- Stage register, every cycle: stg <= {noc_to_dev_ctl, noc_to_dev_data, cmd_des}, using the pre-edge cmd_des.
- Edge detect:
  - ctl_q <= noc_to_dev_ctl every cycle.
  - ctl_f = ctl_q & ~noc_to_dev_ctl, combinational and same-cycle.
  - The rising detector (ctl_r = ~ctl_q & noc_to_dev_ctl) is implemented internally but unused.
- On a posedge with ctl_f=1:
  - alen <= 1<<stg[15:14] (1,2,4,8).
  - dlen <= 1<<stg[13:11] (1..128).
  - cmd_des <= noc_to_dev_data.
  - cnt (10 bit) <= alen_new + dlen_new + 2 (range 4..138).
- On a posedge with ctl_f=0 and cnt!=0: cnt <= cnt-1.
- cmd_busy = (cnt!=0).
- FIFO write enable: wr = ctl_f | (cnt!=0); the written word is stg.
  - A burst writes 1 + alen + dlen + 2 words: header word first, then the following stage words.
- A new ctl_f during an active burst reloads cnt (restart); no error is flagged.
- FIFO:
  - Write when wr & ~full: mem[wptr] <= stg, wptr wraps modulo DEPTH.
  - Read when rd_en & ~empty: data_out <= mem[rptr], rptr wraps.
  - data_out holds its value when there is no read.
  - Full with wr & rd_en: both occur, count unchanged.
  - Empty with wr & rd_en: write only; read ignored, data_out held.
  - Write while full without a read: word dropped.
  - Read while empty: ignored.
  - empty/full are registered, derived from count (0 / DEPTH), and valid the cycle after the update.

Optional Feature:
- Macro: NOC_INGRESS_OVF_EN.
- Defined: ovf sets on any cycle with wr & full & ~rd_en. It is sticky until reset.
- Undefined: ovf tied 0 and no overflow logic.
- Dropped-word behaviour is identical in both builds.

Test Plan:
- Reset mid-burst: assert rst during a burst with 3 words queued -> empty=1, cmd_busy=0, data_out=0 immediately (asynchronous).
- Minimal header: ctl=1 with data 0x00 for one cycle, then ctl=0 with data 0x5A, then bytes 0x01..0x04 -> exactly 5 FIFO writes; first word {1,0x00,0x00}; cmd_des=0x5A; cmd_busy high for 4 cycles.
- Header 0xC0: cnt loaded to 11, 12 words total. Draining with rd_en pops words in order, with data_out updating one cycle after each rd_en.
- Header 0x38: dlen=128, cnt=131. Hold rd_en=0 -> full asserts after 16 writes and the rest are dropped. With NOC_INGRESS_OVF_EN, ovf=1 and stays set.
- Simultaneous rd_en & wr while full -> count stays 16, full stays 1, and the oldest word appears on data_out. rd_en on empty -> data_out unchanged, empty stays 1.
- Second header arriving while cnt=3 -> cnt reloads to the new value; cmd_des takes the new destination byte.
